// File: rtl/mc_control_fsm.sv
// Multicycle control FSM with memory-wait timeout and a sticky FAULT state.
// Define MC_CONTROL_JAL_EN to add the JALWB state; otherwise JAL is an unsupported opcode.
module mc_control_fsm #(
  parameter int unsigned ALUOP_W      = 3,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               memready,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               bne,
  output logic               iord,
  output logic               immzext,
  output logic               memreq,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               fault,
  output logic               illop
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 32'd0) ? $clog2(WAIT_TIMEOUT + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_TIMEOUT);
  localparam bit TIMEOUT_EN = (WAIT_TIMEOUT != 32'd0);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'd5);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
`ifdef MC_CONTROL_JAL_EN
    S_JALWB   = 4'd14,
`endif
    S_FAULT   = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting_s;
  logic             timeout_s;

  function automatic logic op_supported(input logic [5:0] opc);
    logic ok;
    case (opc)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_J: ok = 1'b1;
`ifdef MC_CONTROL_JAL_EN
      OP_JAL:                         ok = 1'b1;
`endif
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // The counter holds completed wait cycles; a wait cycle seen with the count already at the limit faults.
  assign timeout_s = TIMEOUT_EN && waiting_s && !memready && (cnt_q == CNT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (memready)       state_d = S_DECODE;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_R:                     state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI:                  state_d = S_ADDIEX;
          OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
          OP_J:                     state_d = S_JUMP;
`ifdef MC_CONTROL_JAL_EN
          OP_JAL:                   state_d = S_JALWB;
`endif
          default:                  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (memready)       state_d = S_MEMWB;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (memready)       state_d = S_FETCH;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_MEMWR;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_IMMWB;
      S_IMMEX:   state_d = S_IMMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_ALUWB:   state_d = S_FETCH;
      S_IMMWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
`ifdef MC_CONTROL_JAL_EN
      S_JALWB:   state_d = S_FETCH;
`endif
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FETCH;
    endcase

    if (TIMEOUT_EN && waiting_s && !memready && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pcwrite  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    iord     = 1'b0;
    immzext  = 1'b0;
    memreq   = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    fault    = 1'b0;
    illop    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        // The state register already reads FETCH while reset is held, so gate the strobes here.
        pcwrite = memready && !reset;
        irwrite = memready && !reset;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illop   = !op_supported(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        memreq = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memreq   = 1'b1;
        memwrite = memready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        bne     = (op == OP_BNE);
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin aluop = ALU_AND; immzext = 1'b1; end
          OP_ORI:  begin aluop = ALU_OR;  immzext = 1'b1; end
          OP_SLTI: begin aluop = ALU_SLT; immzext = 1'b0; end
          default: begin aluop = ALU_ADD; immzext = 1'b0; end
        endcase
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
`ifdef MC_CONTROL_JAL_EN
      S_JALWB: begin
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
      end
`endif
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm built with WAIT_TIMEOUT=4.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       memready = 1'b0;
  logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, immzext, memreq;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] aluop;
  logic       fault, illop;

  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.ALUOP_W(3), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .branch(branch), .bne(bne), .iord(iord), .immzext(immzext),
    .memreq(memreq), .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .fault(fault), .illop(illop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, immzext, memreq;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] aluop;
    logic fault, illop;
  } outv_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    outv_t      exp;
    string      name;
  } vec_t;

  outv_t got;
  assign got = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, immzext,
                memreq, regdst, memtoreg, alusrcb, pcsrc, aluop, fault, illop};

  vec_t tbl[$];

  function automatic outv_t e_fetch(input logic strobe);
    outv_t e = '0;
    e.memreq = 1'b1; e.alusrcb = 2'b01; e.pcwrite = strobe; e.irwrite = strobe;
    return e;
  endfunction
  function automatic outv_t e_decode(input logic ill);
    outv_t e = '0;
    e.alusrcb = 2'b11; e.illop = ill;
    return e;
  endfunction
  function automatic outv_t e_adr();
    outv_t e = '0;
    e.alusrca = 1'b1; e.alusrcb = 2'b10;
    return e;
  endfunction
  function automatic outv_t e_memrd();
    outv_t e = '0;
    e.iord = 1'b1; e.memreq = 1'b1;
    return e;
  endfunction
  function automatic outv_t e_memwb();
    outv_t e = '0;
    e.regwrite = 1'b1; e.memtoreg = 2'b01;
    return e;
  endfunction
  function automatic outv_t e_memwr(input logic wr);
    outv_t e = '0;
    e.iord = 1'b1; e.memreq = 1'b1; e.memwrite = wr;
    return e;
  endfunction
  function automatic outv_t e_execute();
    outv_t e = '0;
    e.alusrca = 1'b1; e.aluop = 3'd2;
    return e;
  endfunction
  function automatic outv_t e_aluwb();
    outv_t e = '0;
    e.regwrite = 1'b1; e.regdst = 2'b01;
    return e;
  endfunction
  function automatic outv_t e_branch(input logic ne);
    outv_t e = '0;
    e.alusrca = 1'b1; e.branch = 1'b1; e.bne = ne; e.aluop = 3'd1; e.pcsrc = 2'b01;
    return e;
  endfunction
  function automatic outv_t e_immex(input logic [2:0] alu, input logic zx);
    outv_t e = '0;
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = alu; e.immzext = zx;
    return e;
  endfunction
  function automatic outv_t e_immwb();
    outv_t e = '0;
    e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic outv_t e_jump();
    outv_t e = '0;
    e.pcwrite = 1'b1; e.pcsrc = 2'b10;
    return e;
  endfunction
  function automatic outv_t e_jalwb();
    outv_t e = '0;
    e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10; e.pcwrite = 1'b1; e.pcsrc = 2'b10;
    return e;
  endfunction
  function automatic outv_t e_fault();
    outv_t e = '0;
    e.fault = 1'b1;
    return e;
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic m, input outv_t e,
                     input string n);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // One cycle: drive at the falling edge, compare 1 ns later, state advances on the next rising edge.
  task automatic step(input logic r, input logic [5:0] o, input logic m, input outv_t e,
                      input string n);
    @(negedge clk);
    reset = r; op = o; memready = m;
    #1;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, got, e);
    end
  endtask

  initial begin
    add(1'b1, OP_LW, 1'b1, e_fetch(1'b0), "reset_state");
    add(1'b0, OP_LW, 1'b1, e_fetch(1'b1), "lw_fetch");
    add(1'b0, OP_LW, 1'b1, e_decode(1'b0), "lw_decode");
    add(1'b0, OP_LW, 1'b1, e_adr(), "lw_memadr");
    add(1'b0, OP_LW, 1'b1, e_memrd(), "lw_memrd");
    add(1'b0, OP_LW, 1'b1, e_memwb(), "lw_memwb");
    add(1'b0, OP_SW, 1'b1, e_fetch(1'b1), "sw_fetch");
    add(1'b0, OP_SW, 1'b1, e_decode(1'b0), "sw_decode");
    add(1'b0, OP_SW, 1'b1, e_adr(), "sw_memadr");
    add(1'b0, OP_SW, 1'b0, e_memwr(1'b0), "sw_memwr_wait");
    add(1'b0, OP_SW, 1'b1, e_memwr(1'b1), "sw_memwr_done");
    add(1'b0, OP_R, 1'b1, e_fetch(1'b1), "r_fetch");
    add(1'b0, OP_R, 1'b1, e_decode(1'b0), "r_decode");
    add(1'b0, OP_R, 1'b1, e_execute(), "r_execute");
    add(1'b0, OP_R, 1'b1, e_aluwb(), "r_aluwb");
    add(1'b0, OP_BEQ, 1'b1, e_fetch(1'b1), "beq_fetch");
    add(1'b0, OP_BEQ, 1'b1, e_decode(1'b0), "beq_decode");
    add(1'b0, OP_BEQ, 1'b1, e_branch(1'b0), "beq_branch");
    add(1'b0, OP_BNE, 1'b1, e_fetch(1'b1), "bne_fetch");
    add(1'b0, OP_BNE, 1'b1, e_decode(1'b0), "bne_decode");
    add(1'b0, OP_BNE, 1'b1, e_branch(1'b1), "bne_branch");
    add(1'b0, OP_ADDI, 1'b1, e_fetch(1'b1), "addi_fetch");
    add(1'b0, OP_ADDI, 1'b1, e_decode(1'b0), "addi_decode");
    add(1'b0, OP_ADDI, 1'b1, e_adr(), "addi_addiex");
    add(1'b0, OP_ADDI, 1'b1, e_immwb(), "addi_immwb");
    add(1'b0, OP_ANDI, 1'b1, e_fetch(1'b1), "andi_fetch");
    add(1'b0, OP_ANDI, 1'b1, e_decode(1'b0), "andi_decode");
    add(1'b0, OP_ANDI, 1'b1, e_immex(3'd3, 1'b1), "andi_immex");
    add(1'b0, OP_ANDI, 1'b1, e_immwb(), "andi_immwb");
    add(1'b0, OP_ORI, 1'b1, e_fetch(1'b1), "ori_fetch");
    add(1'b0, OP_ORI, 1'b1, e_decode(1'b0), "ori_decode");
    add(1'b0, OP_ORI, 1'b1, e_immex(3'd4, 1'b1), "ori_immex");
    add(1'b0, OP_ORI, 1'b1, e_immwb(), "ori_immwb");
    add(1'b0, OP_SLTI, 1'b1, e_fetch(1'b1), "slti_fetch");
    add(1'b0, OP_SLTI, 1'b1, e_decode(1'b0), "slti_decode");
    add(1'b0, OP_SLTI, 1'b1, e_immex(3'd5, 1'b0), "slti_immex");
    add(1'b0, OP_SLTI, 1'b1, e_immwb(), "slti_immwb");
    add(1'b0, OP_J, 1'b1, e_fetch(1'b1), "j_fetch");
    add(1'b0, OP_J, 1'b1, e_decode(1'b0), "j_decode");
    add(1'b0, OP_J, 1'b1, e_jump(), "j_jump");
    add(1'b0, OP_JAL, 1'b1, e_fetch(1'b1), "jal_fetch");
`ifdef MC_CONTROL_JAL_EN
    add(1'b0, OP_JAL, 1'b1, e_decode(1'b0), "jal_decode");
    add(1'b0, OP_JAL, 1'b1, e_jalwb(), "jal_jalwb");
`else
    add(1'b0, OP_JAL, 1'b1, e_decode(1'b1), "jal_illop");
`endif
    add(1'b0, OP_BAD, 1'b1, e_fetch(1'b1), "bad_fetch");
    add(1'b0, OP_BAD, 1'b1, e_decode(1'b1), "bad_illop");
    // Back in FETCH: illop has dropped, then three wait cycles before the fetch completes.
    add(1'b0, OP_R, 1'b0, e_fetch(1'b0), "fetch_wait1");
    add(1'b0, OP_R, 1'b0, e_fetch(1'b0), "fetch_wait2");
    add(1'b0, OP_R, 1'b0, e_fetch(1'b0), "fetch_wait3");
    add(1'b0, OP_R, 1'b1, e_fetch(1'b1), "fetch_ready");
    add(1'b0, OP_R, 1'b1, e_decode(1'b0), "fetch_then_decode");
    add(1'b0, OP_R, 1'b1, e_execute(), "fw_execute");
    add(1'b0, OP_R, 1'b1, e_aluwb(), "fw_aluwb");

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].exp, tbl[i].name);
    end

    // Timeout: five MEMRD cycles without memready (count 0..4), then FAULT holds until reset.
    step(1'b0, OP_LW, 1'b1, e_fetch(1'b1), "to_fetch");
    step(1'b0, OP_LW, 1'b1, e_decode(1'b0), "to_decode");
    step(1'b0, OP_LW, 1'b1, e_adr(), "to_memadr");
    for (int k = 0; k < 5; k++) step(1'b0, OP_LW, 1'b0, e_memrd(), "to_memrd_wait");
    for (int k = 0; k < 3; k++) step(1'b0, (k == 1) ? OP_R : OP_LW, 1'b1, e_fault(), "to_fault_held");
    step(1'b1, OP_LW, 1'b0, e_fetch(1'b0), "to_reset_clears");
    step(1'b0, OP_LW, 1'b1, e_fetch(1'b1), "to_after_reset");

    // memready arriving in the cycle the count sits at the limit wins over the timeout.
    step(1'b0, OP_LW, 1'b1, e_decode(1'b0), "prio_decode");
    step(1'b0, OP_LW, 1'b1, e_adr(), "prio_memadr");
    for (int k = 0; k < 4; k++) step(1'b0, OP_LW, 1'b0, e_memrd(), "prio_memrd_wait");
    step(1'b0, OP_LW, 1'b1, e_memrd(), "prio_ready_at_limit");
    step(1'b0, OP_LW, 1'b1, e_memwb(), "prio_memwb");

    // Reset in the middle of a store abandons it; memwrite must not fire during reset.
    step(1'b0, OP_SW, 1'b1, e_fetch(1'b1), "rst_sw_fetch");
    step(1'b0, OP_SW, 1'b1, e_decode(1'b0), "rst_sw_decode");
    step(1'b0, OP_SW, 1'b1, e_adr(), "rst_sw_memadr");
    step(1'b0, OP_SW, 1'b0, e_memwr(1'b0), "rst_sw_memwr_wait");
    step(1'b1, OP_SW, 1'b1, e_fetch(1'b0), "rst_mid_access");
    step(1'b1, OP_SW, 1'b1, e_fetch(1'b0), "rst_held");
    step(1'b0, OP_SW, 1'b0, e_fetch(1'b0), "rst_release_fetch");
    step(1'b0, OP_SW, 1'b1, e_fetch(1'b1), "rst_release_ready");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
